// File: rtl/dds_multichan_gen.sv
// dds_multichan_gen: N-channel DDS source with key-stepped frequency/phase tables,
// computed waveforms, optional automatic frequency sweep and a global phase re-align.

module dds_debounce #(
   parameter int DEB_CYC = 1_000_000
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic Key,
   output logic Press
);
   localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

   logic [1:0]    sync_q;
   logic [1:0]    fill_q;
   logic          stable_q;
   logic          armed_q;
   logic [CW-1:0] cnt_q;

   // Events are armed only once a genuine released level has passed the synchroniser,
   // so a key held down across reset cannot fire when its stable state first drops.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sync_q   <= 2'b11;
         fill_q   <= 2'b00;
         stable_q <= 1'b1;
         armed_q  <= 1'b0;
         cnt_q    <= '0;
         Press    <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], Key};
         fill_q <= {fill_q[0], 1'b1};
         Press  <= 1'b0;
         if (fill_q[1] && sync_q[1])
            armed_q <= 1'b1;
         if (sync_q[1] == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DEB_CYC - 1)) begin
            cnt_q    <= '0;
            stable_q <= sync_q[1];
            Press    <= armed_q & ~sync_q[1];
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end
endmodule

module dds_multichan_gen #(
   parameter int CH          = 2,
   parameter int DW          = 14,
   parameter int AW          = 32,
   parameter int PW          = 12,
   parameter int CLK_HZ      = 50_000_000,
   parameter int DEB_CYC     = 1_000_000,
   parameter int SWEEP_DWELL = 5_000_000
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [CH-1:0]    Key_freq,
   input  logic [CH-1:0]    Key_phase,
   input  logic [2*CH-1:0]  Wave_sel,
   input  logic [CH-1:0]    Sweep_en,
   input  logic             Phase_sync,
   output logic [CH*DW-1:0] Data,
   output logic             Data_valid,
   output logic [CH-1:0]    Dac_clk
);
   localparam int DWL_W = (SWEEP_DWELL > 1) ? $clog2(SWEEP_DWELL) : 1;

   function automatic logic [AW-1:0] fword_of(input int unsigned f);
      logic [AW+23:0] num;
      num = (AW+24)'(f) << AW;
      return AW'(num / (AW+24)'(CLK_HZ));
   endfunction

   // Tuning words are elaboration-time constants; only an 8-entry ROM is built.
   localparam logic [AW-1:0] FWORD [8] = '{
      fword_of(100),     fword_of(1_000),   fword_of(2_000),     fword_of(10_000),
      fword_of(20_000),  fword_of(100_000), fword_of(1_000_000), fword_of(5_000_000)
   };

   assign Dac_clk = {CH{Clk}};

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         Data_valid <= 1'b0;
      else
         Data_valid <= 1'b1;
   end

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic             freq_press;
      logic             phase_press;
      logic             expire;
      logic [2:0]       freq_idx;
      logic [2:0]       phase_idx;
      logic [DWL_W-1:0] dwell_q;
      logic [AW-1:0]    fword_q;
      logic [PW-1:0]    poff_q;
      logic [AW-1:0]    acc_q;
      logic [AW-1:0]    ph;
      logic [DW-1:0]    saw;
      logic [DW-1:0]    tri_lo;
      logic [DW-1:0]    wave_d;
      logic [DW-1:0]    data_q;

      dds_debounce #(.DEB_CYC(DEB_CYC)) u_deb_freq (
         .Clk     (Clk),
         .Reset_n (Reset_n),
         .Key     (Key_freq[c]),
         .Press   (freq_press)
      );

      dds_debounce #(.DEB_CYC(DEB_CYC)) u_deb_phase (
         .Clk     (Clk),
         .Reset_n (Reset_n),
         .Key     (Key_phase[c]),
         .Press   (phase_press)
      );

      assign expire = Sweep_en[c] && (dwell_q == DWL_W'(SWEEP_DWELL - 1));

      // A press and a dwell expiry in the same cycle still advance the index only once.
      always_ff @(posedge Clk or negedge Reset_n) begin
         if (!Reset_n) begin
            freq_idx  <= '0;
            phase_idx <= '0;
            dwell_q   <= '0;
         end else begin
            if (freq_press || expire)
               freq_idx <= freq_idx + 3'd1;
            if (phase_press)
               phase_idx <= phase_idx + 3'd1;
            if (!Sweep_en[c] || freq_press || expire)
               dwell_q <= '0;
            else
               dwell_q <= dwell_q + 1'b1;
         end
      end

      // Table changes never touch the accumulator, keeping frequency hops phase-continuous.
      always_ff @(posedge Clk or negedge Reset_n) begin
         if (!Reset_n) begin
            fword_q <= FWORD[0];
            poff_q  <= '0;
            acc_q   <= '0;
         end else begin
            fword_q <= FWORD[freq_idx];
            poff_q  <= PW'(phase_idx) << (PW - 3);
            if (Phase_sync)
               acc_q <= '0;
            else
               acc_q <= acc_q + fword_q;
         end
      end

      assign ph     = acc_q + (AW'(poff_q) << (AW - PW));
      assign saw    = DW'(ph >> (AW - DW));
      assign tri_lo = DW'(ph >> (AW - 1 - DW));

      always_comb begin
         wave_d = saw;
         case (Wave_sel[2*c +: 2])
            2'b00:   wave_d = saw;
            2'b01:   wave_d = ph[AW-1] ? ~tri_lo : tri_lo;
            2'b10:   wave_d = ph[AW-1] ? '0 : {DW{1'b1}};
            default: wave_d = DW'(1) << (DW - 1);
         endcase
      end

      always_ff @(posedge Clk or negedge Reset_n) begin
         if (!Reset_n)
            data_q <= '0;
         else
            data_q <= wave_d;
      end

      assign Data[DW*c +: DW] = data_q;
   end
endmodule

// File: tb/tb_dds_multichan_gen.sv
// Randomised bench for dds_multichan_gen, checked against an arithmetic model of
// channel phase (k*Fword + phase_idx*45deg) and the waveform definitions.
`timescale 1ns/1ps
module tb_dds_multichan_gen;
   localparam int CH          = 2;
   localparam int DW          = 14;
   localparam int AW          = 32;
   localparam int PW          = 12;
   localparam int CLK_HZ      = 50_000_000;
   localparam int DEB_CYC     = 16;
   localparam int SWEEP_DWELL = 64;

   logic             Clk = 1'b0;
   logic             Reset_n;
   logic [CH-1:0]    Key_freq;
   logic [CH-1:0]    Key_phase;
   logic [2*CH-1:0]  Wave_sel;
   logic [CH-1:0]    Sweep_en;
   logic             Phase_sync;
   logic [CH*DW-1:0] Data;
   logic             Data_valid;
   logic [CH-1:0]    Dac_clk;

   int vectors     = 0;
   int miscompares = 0;
   int m_fidx [CH];
   int m_pidx [CH];
   longint unsigned freq_hz [8] = '{100, 1_000, 2_000, 10_000, 20_000, 100_000, 1_000_000, 5_000_000};

   dds_multichan_gen #(
      .CH(CH), .DW(DW), .AW(AW), .PW(PW), .CLK_HZ(CLK_HZ),
      .DEB_CYC(DEB_CYC), .SWEEP_DWELL(SWEEP_DWELL)
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .Key_freq   (Key_freq),
      .Key_phase  (Key_phase),
      .Wave_sel   (Wave_sel),
      .Sweep_en   (Sweep_en),
      .Phase_sync (Phase_sync),
      .Data       (Data),
      .Data_valid (Data_valid),
      .Dac_clk    (Dac_clk)
   );

   always #5 Clk = ~Clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge Clk);
   endtask

   function automatic longint unsigned fword_model(input int idx);
      return (freq_hz[idx] * 64'd4294967296) / longint'(CLK_HZ);
   endfunction

   function automatic logic [DW-1:0] wave_model(input longint unsigned ph, input logic [1:0] sel);
      longint unsigned half;
      half = 64'd1 << 31;
      case (sel)
         2'b00:   return DW'(ph / (64'd1 << 18));
         2'b01:   return (ph < half) ? DW'(ph / (64'd1 << 17)) : DW'((64'hFFFF_FFFF - ph) / (64'd1 << 17));
         2'b10:   return (ph < half) ? 14'h3FFF : 14'h0000;
         default: return 14'h2000;
      endcase
   endfunction

   function automatic logic [DW-1:0] expected_data(input int c, input longint unsigned k);
      longint unsigned ph;
      ph = (k * fword_model(m_fidx[c]) + longint'(m_pidx[c]) * (64'd1 << 29)) & 64'hFFFF_FFFF;
      return wave_model(ph, Wave_sel[2*c +: 2]);
   endfunction

   task automatic set_key(input int ch, input bit phase_key, input logic v);
      if (phase_key) Key_phase[ch] = v;
      else           Key_freq[ch]  = v;
   endtask

   // One key press (optionally bounced), long enough to debounce both edges.
   task automatic applyStimulus(input int ch, input bit phase_key, input bit bounce);
      if (bounce)
         for (int i = 0; i < 10; i++) begin
            set_key(ch, phase_key, logic'($urandom_range(0, 1)));
            step(1);
         end
      set_key(ch, phase_key, 1'b0);
      step(DEB_CYC + 8);
      set_key(ch, phase_key, 1'b1);
      step(DEB_CYC + 8);
      if (phase_key) m_pidx[ch] = (m_pidx[ch] + 1) % 8;
      else           m_fidx[ch] = (m_fidx[ch] + 1) % 8;
   endtask

   // Leaves the bench at the sample point where Data reflects acc = 0.
   task automatic sync_pulse();
      Phase_sync = 1'b1;
      step(1);
      Phase_sync = 1'b0;
      step(1);
   endtask

   task automatic check_phases(input string tag);
      longint unsigned k;
      int gap;
      sync_pulse();
      k = 0;
      for (int s = 0; s < 5; s++) begin
         for (int c = 0; c < CH; c++)
            checkOutput($sformatf("%s_ch%0d_k%0d", tag, c, k), 64'(Data[DW*c +: DW]), 64'(expected_data(c, k)));
         gap = (s == 3) ? int'($urandom_range(2, 1500)) : 1;
         step(gap);
         k += longint'(gap);
      end
   endtask

   task automatic sweep_run(input int edges);
      Sweep_en[0] = 1'b1;
      step(edges);
      Sweep_en[0] = 1'b0;
      m_fidx[0] = (m_fidx[0] + edges / SWEEP_DWELL) % 8;
   endtask

   // A press whose first sampled edge is offset j edges into a one-dwell sweep.
   task automatic sweep_press(input int j);
      Sweep_en[0] = 1'b1;
      step(j);
      Key_freq[0] = 1'b0;
      step(SWEEP_DWELL - j);
      Sweep_en[0] = 1'b0;
      step(DEB_CYC + 8);
      Key_freq[0] = 1'b1;
      step(DEB_CYC + 8);
      m_fidx[0] = (m_fidx[0] + 1) % 8;
   endtask

   initial begin
      Reset_n    = 1'b0;
      Key_freq   = '1;
      Key_phase  = '1;
      Wave_sel   = '0;
      Sweep_en   = '0;
      Phase_sync = 1'b0;
      for (int c = 0; c < CH; c++) begin
         m_fidx[c] = 0;
         m_pidx[c] = 0;
      end

      step(3);
      checkOutput("reset_data", 64'(Data), 64'd0);
      checkOutput("reset_valid", 64'(Data_valid), 64'd0);
      Reset_n = 1'b1;
      step(1);
      checkOutput("valid_first_edge", 64'(Data_valid), 64'd1);
      checkOutput("first_sample", 64'(Data), 64'd0);
      step(1000);
      checkOutput("free_run_ch0", 64'(Data[DW-1:0]), 64'(expected_data(0, 1000)));
      checkOutput("dac_clk_low", 64'(Dac_clk), 64'd0);
      @(posedge Clk);
      #1;
      checkOutput("dac_clk_high", 64'(Dac_clk), 64'(2'b11));
      step(1);
      check_phases("idle");

      applyStimulus(0, 1'b0, 1'b1);
      check_phases("bounced_press");
      for (int i = 0; i < 7; i++) applyStimulus(0, 1'b0, 1'b0);
      check_phases("fidx_wrap");

      applyStimulus(0, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 1'b0);
      applyStimulus(1, 1'b1, 1'b1);
      applyStimulus(1, 1'b1, 1'b0);
      sync_pulse();
      checkOutput("sync_ch0", 64'(Data[DW-1:0]), 64'd0);
      checkOutput("sync_ch1_90deg", 64'(Data[2*DW-1:DW]), 64'h1000);
      check_phases("two_phase_steps");

      sweep_run(3 * SWEEP_DWELL + 10);
      check_phases("sweep_3");
      sweep_run(8 * SWEEP_DWELL);
      check_phases("sweep_wrap");
      sweep_run(SWEEP_DWELL - 1);
      check_phases("sweep_short");
      sweep_run(SWEEP_DWELL);
      check_phases("sweep_exact");
      sweep_press(SWEEP_DWELL - DEB_CYC - 3);
      check_phases("press_on_expiry");
      sweep_press(20);
      check_phases("press_mid_dwell");

      while (m_fidx[0] != 7) applyStimulus(0, 1'b0, 1'b0);
      while (m_pidx[0] != 4) applyStimulus(0, 1'b1, 1'b0);
      Wave_sel[1:0] = 2'b01;
      sync_pulse();
      checkOutput("tri_peak", 64'(Data[DW-1:0]), 64'h3FFF);
      check_phases("tri_5mhz");
      Wave_sel[1:0] = 2'b10;
      sync_pulse();
      checkOutput("square_low", 64'(Data[DW-1:0]), 64'h0000);
      check_phases("square_5mhz");
      Wave_sel[1:0] = 2'b11;
      for (int i = 0; i < 3; i++) begin
         step(int'($urandom_range(1, 7)));
         checkOutput($sformatf("mute_%0d", i), 64'(Data[DW-1:0]), 64'h2000);
      end

      for (int r = 0; r < 6; r++) begin
         int ch;
         ch = int'($urandom_range(0, CH - 1));
         repeat ($urandom_range(0, 2)) applyStimulus(ch, 1'b0, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) applyStimulus(ch, 1'b1, 1'($urandom_range(0, 1)));
         Wave_sel = ($urandom_range(0, 15));
         check_phases($sformatf("rand%0d", r));
      end

      Wave_sel    = '0;
      Sweep_en[0] = 1'b1;
      Key_freq[0] = 1'b0;
      step(30);
      Reset_n = 1'b0;
      #1;
      checkOutput("async_reset_data", 64'(Data), 64'd0);
      checkOutput("async_reset_valid", 64'(Data_valid), 64'd0);
      Sweep_en[0] = 1'b0;
      for (int c = 0; c < CH; c++) begin
         m_fidx[c] = 0;
         m_pidx[c] = 0;
      end
      step(3);
      Reset_n = 1'b1;
      step(1);
      checkOutput("valid_after_reset", 64'(Data_valid), 64'd1);
      step(DEB_CYC + 10);
      Key_freq[0] = 1'b1;
      step(DEB_CYC + 8);
      check_phases("held_key_no_event");
      applyStimulus(0, 1'b0, 1'b0);
      check_phases("press_after_release");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
